alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin request arbiter and sequencer for the shared 6-bit combinational ALU datapath (mode/A/B in; out/overflow/carry-out back).

- Two requesters submit (mode, A, B) operations through valid/ready handshakes.
- The block grants one request at a time and drives the ALU from registered operands.
- It samples the ALU result and returns it, tagged with the requester ID, over a response handshake with backpressure.
- It sits between the ALU instance and its clients, for example switch/button capture logic and a self-test sweeper on the Basys3 top level.

## Interface

Parameters:
- `W`, default 6: operand and result width; must match the ALU width.
- `MODE_W`, default 3: ALU mode select width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_mode` in MODE_W: requester 0 ALU mode.
- `req0_a` in W: requester 0 operand A.
- `req0_b` in W: requester 0 operand B.
- `req1_valid`, `req1_ready`, `req1_mode`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `alu_mode` out MODE_W: mode driven to the ALU.
- `alu_a` out W: operand A driven to the ALU.
- `alu_b` out W: operand B driven to the ALU.
- `alu_out` in W: ALU result.
- `alu_ovf` in 1: ALU overflow flag.
- `alu_cout` in 1: ALU carry-out flag.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_data` out W: captured result.
- `rsp_ovf` out 1: captured overflow flag.
- `rsp_cout` out 1: captured carry-out flag.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

The FSM has three states: IDLE, EXEC and RESP.

**IDLE**
- Grant selection:
  - Both valids high: grant the requester named by the priority pointer `prio`.
  - Only one valid high: grant that requester.
  - No valid high: no grant.
- `reqN_ready` is combinational and high only for the granted requester while in IDLE.
- When the handshake completes (valid & ready):
  - Latch mode, A and B into the operand registers.
  - Latch the requester number into `id_q`.
  - Go to EXEC.

**EXEC**
- `alu_*` outputs present the operand registers; the ALU settles within the cycle.
- At the end of the cycle, capture `alu_out`, `alu_ovf` and `alu_cout` into the response registers.
- Set `rsp_valid` and go to RESP.

**RESP**
- Hold `rsp_*` stable while `rsp_valid` is high and `rsp_ready` is low.
- When `rsp_valid` and `rsp_ready` are both high:
  - Clear `rsp_valid`.
  - Set `prio` to the complement of `id_q`, so the other requester wins the next tie.
  - Go to IDLE.

**General rules**
- `alu_mode`, `alu_a` and `alu_b` always reflect the operand registers. They change only on acceptance and stay unchanged in all other cycles, so the ALU sees no glitch-driven mode changes.
- The block performs no arithmetic. Result and flags pass through unmodified, W bits wide, with no sign extension.
- Requesters must hold valid, mode, A and B stable until accepted. A request dropped before acceptance is simply never serviced.
- Both `req*_ready` are low in EXEC and RESP. New requests wait and are not queued.
- A single requester may be granted back to back when the other is idle; fairness applies only to ties.

## Timing

- Reset values:
  - State = IDLE.
  - `prio` = 0.
  - Operand registers, `alu_mode`, `alu_a`, `alu_b` = 0.
  - `rsp_valid` = 0; `rsp_id` = 0; `rsp_data` = 0; `rsp_ovf` = 0; `rsp_cout` = 0.
  - `busy` = 0.
  - Both `req*_ready` = 0.
- Latency: a request accepted in cycle N produces `rsp_valid` high in cycle N+2.
- Throughput: with `rsp_ready` held high, at most one operation per 3 cycles (accept N, respond N+2, next accept N+3).
- Response handshake: the response completes in the first cycle where `rsp_valid` and `rsp_ready` are both high, including the first cycle of RESP.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response, and all outputs return to reset values on the next edge.
- `rst` and a handshake in the same cycle: reset wins; the request is not accepted.
- `rsp_ready` high while `rsp_valid` is low: ignored.

## Test plan

- Single add, real ALU attached:
  - Stimulus: requester 0 sends mode=110, A=6'd20, B=6'd15.
  - Required: ready for 1 cycle; `alu_mode`=110 the next cycle; `rsp_valid` 2 cycles after acceptance with `rsp_id`=0, `rsp_data`=6'd35, `rsp_ovf`=1, `rsp_cout`=0.
- Single subtract:
  - Stimulus: requester 1 sends mode=111, A=6'd5, B=6'd9.
  - Required: `rsp_id`=1, `rsp_data`=6'd60 (-4), `rsp_ovf`=0, `rsp_cout`=0.
- Tie and round-robin:
  - Stimulus: both requesters continuously valid after reset, `rsp_ready`=1.
  - Required: grants alternate 0,1,0,1; each response's `rsp_id` matches its grant; accepts exactly 3 cycles apart.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - Required: `rsp_*` stable, both `req*_ready`=0 and `busy`=1 throughout; completion in the cycle `rsp_ready` rises; IDLE on the next cycle.
- Reset during EXEC and during RESP:
  - Required: no response is delivered; every output equals its reset value one cycle later; `prio`=0, so a tie after reset grants requester 0.
- Operand hold:
  - Stimulus: change the requester's A/B while the block is in RESP.
  - Required: `alu_a`, `alu_b` and `rsp_data` remain unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_arbiter                                                    |
// | Purpose : Round-robin arbiter and sequencer for a shared combinational   |
// |           ALU. Two requesters hand over (mode, A, B) through valid/ready.|
// |           The granted operation is registered, driven to the ALU for one |
// |           cycle, and the sampled result is returned with the requester   |
// |           ID over a response handshake that supports backpressure.       |
// | Ports   : clk, rst         - clock, synchronous active-high reset        |
// |           reqN_valid/ready - request handshake, requester N (0 or 1)     |
// |           reqN_mode/a/b    - requester N operation                       |
// |           alu_mode/a/b     - registered operands to the ALU              |
// |           alu_out/ovf/cout - ALU result and flags                        |
// |           rsp_valid/ready  - response handshake                          |
// |           rsp_id/data/ovf/cout - captured response                       |
// |           busy             - high whenever the FSM is not idle           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int W      = 6,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [MODE_W-1:0] req1_mode,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  output logic [MODE_W-1:0] alu_mode,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_ovf,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                prio_q;
  logic                id_q;
  logic [MODE_W-1:0]   mode_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [W-1:0]        rsp_data_q;
  logic                rsp_ovf_q;
  logic                rsp_cout_q;

  logic                w_gnt_any;
  logic                w_gnt_id;
  logic                w_accept;

  // A tie goes to the priority pointer; otherwise the lone valid requester
  // wins (req1_valid alone selects 1, req0_valid alone selects 0).
  always_comb begin
    w_gnt_any = req0_valid | req1_valid;
    w_gnt_id  = (req0_valid & req1_valid) ? prio_q : req1_valid;
    // Reset suppresses ready so a request seen during reset is never
    // considered accepted by the requester.
    w_accept  = !rst && (state_q == ST_IDLE) && w_gnt_any;
  end

  assign req0_ready = w_accept & ~w_gnt_id;
  assign req1_ready = w_accept &  w_gnt_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      mode_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Operand registers load only here, so the ALU inputs never
          // change outside an acceptance.
          if (w_accept) begin
            mode_q  <= w_gnt_id ? req1_mode : req0_mode;
            a_q     <= w_gnt_id ? req1_a    : req0_a;
            b_q     <= w_gnt_id ? req1_b    : req0_b;
            id_q    <= w_gnt_id;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_ovf_q   <= alu_ovf;
          rsp_cout_q  <= alu_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            prio_q      <= ~id_q;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_mode  = mode_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_alu_arbiter                                                 |
// | Purpose : Self-checking bench for alu_arbiter with an attached 6-bit ALU |
// |           model and a response scoreboard.                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;
  localparam int W  = 6;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MW-1:0] req0_mode, req1_mode, alu_mode;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic          alu_ovf, alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_cout, busy;

  alu_arbiter #(.W(W), .MODE_W(MW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: returns {ovf, cout, out}.
  function automatic logic [W+1:0] alu_f(logic [MW-1:0] m, logic [W-1:0] a, logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         ov, co;
    s = '0; r = '0; ov = 1'b0; co = 1'b0;
    case (m)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b011: r = ~a;
      3'b100: r = a << 1;
      3'b101: r = a >> 1;
      3'b110: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
    endcase
    return {ov, co, r};
  endfunction

  always_comb {alu_ovf, alu_cout, alu_out} = alu_f(alu_mode, alu_a, alu_b);

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         ovf;
    logic         cout;
  } item_t;

  item_t sb[$];
  int    gnt_q[$];
  int    acc_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    last_acc = -100;
  logic  prev_rv  = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(logic id, logic [MW-1:0] m, logic [W-1:0] a, logic [W-1:0] b);
    item_t       it;
    logic [W+1:0] r;
    r       = alu_f(m, a, b);
    it.id   = id;
    it.data = r[W-1:0];
    it.cout = r[W];
    it.ovf  = r[W+1];
    sb.push_back(it);
    gnt_q.push_back(int'(id));
    acc_q.push_back(cyc);
    last_acc = cyc;
  endtask

  // Per-cycle scoreboard monitor, run at the sample point of every cycle.
  task automatic mon();
    item_t it;
    if (rst) begin
      sb.delete();
      prev_rv = 1'b0;
    end else begin
      chk("dual_grant", 32'(req0_ready & req1_ready), 0);
      if (req0_valid && req0_ready) push(1'b0, req0_mode, req0_a, req0_b);
      if (req1_valid && req1_ready) push(1'b1, req1_mode, req1_a, req1_b);
      if (rsp_valid && !prev_rv) chk("latency", cyc - last_acc, 2);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          chk("sb_id",   32'(rsp_id),   32'(it.id));
          chk("sb_data", 32'(rsp_data), 32'(it.data));
          chk("sb_ovf",  32'(rsp_ovf),  32'(it.ovf));
          chk("sb_cout", 32'(rsp_cout), 32'(it.cout));
        end
      end
      prev_rv = rsp_valid;
    end
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      smp();
      nxt();
    end
  endtask

  task automatic chk_rst_outs(string tag);
    chk({tag, "_ready0"},    32'(req0_ready), 0);
    chk({tag, "_ready1"},    32'(req1_ready), 0);
    chk({tag, "_busy"},      32'(busy),       0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),  0);
    chk({tag, "_rsp_id"},    32'(rsp_id),     0);
    chk({tag, "_rsp_data"},  32'(rsp_data),   0);
    chk({tag, "_rsp_ovf"},   32'(rsp_ovf),    0);
    chk({tag, "_rsp_cout"},  32'(rsp_cout),   0);
    chk({tag, "_alu_mode"},  32'(alu_mode),   0);
    chk({tag, "_alu_a"},     32'(alu_a),      0);
    chk({tag, "_alu_b"},     32'(alu_b),      0);
  endtask

  initial begin
    // Reset with a request pending: reset must win.
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 3'b110; req0_a = 6'd20; req0_b = 6'd15;
    req1_valid = 1'b0; req1_mode = 3'b000; req1_a = 6'd0;  req1_b = 6'd0;
    smp(); chk("por_ready0", 32'(req0_ready), 0); nxt();
    rst = 1'b0; req0_valid = 1'b0;
    smp(); chk_rst_outs("por"); nxt();

    // Single add from requester 0.
    req0_valid = 1'b1; rsp_ready = 1'b1;
    smp(); chk("add_ready0", 32'(req0_ready), 1); chk("add_ready1", 32'(req1_ready), 0); nxt();
    req0_valid = 1'b0;
    smp();
    chk("add_exec_ready0", 32'(req0_ready), 0);
    chk("add_alu_mode", 32'(alu_mode), 6);
    chk("add_alu_a", 32'(alu_a), 20);
    chk("add_alu_b", 32'(alu_b), 15);
    chk("add_exec_busy", 32'(busy), 1);
    chk("add_exec_rv", 32'(rsp_valid), 0);
    nxt();
    smp();
    chk("add_rv", 32'(rsp_valid), 1);
    chk("add_id", 32'(rsp_id), 0);
    chk("add_data", 32'(rsp_data), 35);
    chk("add_ovf", 32'(rsp_ovf), 1);
    chk("add_cout", 32'(rsp_cout), 0);
    nxt();
    smp(); chk("add_done_rv", 32'(rsp_valid), 0); chk("add_done_busy", 32'(busy), 0); nxt();

    // Single subtract from requester 1.
    req1_valid = 1'b1; req1_mode = 3'b111; req1_a = 6'd5; req1_b = 6'd9;
    smp(); chk("sub_ready1", 32'(req1_ready), 1); nxt();
    req1_valid = 1'b0;
    run(1);
    smp();
    chk("sub_rv", 32'(rsp_valid), 1);
    chk("sub_id", 32'(rsp_id), 1);
    chk("sub_data", 32'(rsp_data), 60);
    chk("sub_ovf", 32'(rsp_ovf), 0);
    chk("sub_cout", 32'(rsp_cout), 0);
    nxt();
    run(1);

    // Tie and round-robin after reset.
    rst = 1'b1; run(1); rst = 1'b0;
    gnt_q.delete(); acc_q.delete();
    req0_valid = 1'b1; req0_mode = 3'b110; req0_a = 6'd10; req0_b = 6'd3;
    req1_valid = 1'b1; req1_mode = 3'b111; req1_a = 6'd7;  req1_b = 6'd2;
    rsp_ready = 1'b1;
    run(12);
    req0_valid = 1'b0; req1_valid = 1'b0;
    run(1);
    chk("rr_count", 32'(gnt_q.size()), 4);
    for (int i = 0; i < gnt_q.size(); i++) chk("rr_order", 32'(gnt_q[i]), 32'(i % 2));
    for (int i = 1; i < acc_q.size(); i++) chk("rr_spacing", acc_q[i] - acc_q[i-1], 3);

    // Backpressure with operand hold; other requester waits.
    req0_valid = 1'b1; req0_mode = 3'b110; req0_a = 6'd1; req0_b = 6'd2; rsp_ready = 1'b0;
    smp(); chk("bp_ready0", 32'(req0_ready), 1); nxt();
    req0_valid = 1'b0;
    run(1);
    req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd63;
    req1_valid = 1'b1; req1_mode = 3'b111; req1_a = 6'd12; req1_b = 6'd30;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_rv", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_data", 32'(rsp_data), 3);
      chk("bp_ovf", 32'(rsp_ovf), 0);
      chk("bp_cout", 32'(rsp_cout), 0);
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("hold_alu_a", 32'(alu_a), 1);
      chk("hold_alu_b", 32'(alu_b), 2);
      nxt();
    end
    rsp_ready = 1'b1;
    smp(); chk("bp_complete_rv", 32'(rsp_valid), 1); nxt();
    smp();
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_rv", 32'(rsp_valid), 0);
    chk("bp_tie_ready1", 32'(req1_ready), 1);
    chk("bp_tie_ready0", 32'(req0_ready), 0);
    nxt();
    req1_valid = 1'b0;
    run(3);
    req0_valid = 1'b0;
    run(3);
    chk("sb_drained", 32'(sb.size()), 0);

    // Reset during EXEC (priority pointer currently favours requester 1).
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd7; req0_b = 6'd8;
    smp(); chk("rx_ready0", 32'(req0_ready), 1); nxt();
    req0_valid = 1'b0; rst = 1'b1;
    run(1);
    rst = 1'b0;
    smp(); chk_rst_outs("rst_exec"); nxt();
    req0_valid = 1'b1; req1_valid = 1'b1;
    smp(); chk("rx_tie_ready0", 32'(req0_ready), 1); chk("rx_tie_ready1", 32'(req1_ready), 0); nxt();
    req0_valid = 1'b0; req1_valid = 1'b0;
    run(1);

    // Reset during RESP.
    smp(); chk("rr_resp_rv", 32'(rsp_valid), 1); nxt();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    smp(); chk_rst_outs("rst_resp"); nxt();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    smp(); chk("rr_tie_ready0", 32'(req0_ready), 1); nxt();
    req0_valid = 1'b0; req1_valid = 1'b0;
    run(4);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
